// File: rtl/red_pitaya_guitar_out_level_if.sv
`default_nettype none
// ============================================================================
//  Module   : red_pitaya_guitar_out_level_if
//  Brief    : Sample stream bundle for the guitar output level stage.
//             The master (amplifier side / testbench) drives the input
//             strobe and sample. The slave (level stage) returns the scaled
//             output strobe and sample.
//  Revision : 1.0 - initial release
// ============================================================================
interface red_pitaya_guitar_out_level_if;
    logic        in_valid_i;
    logic [15:0] in_sound_i;
    logic        out_valid_o;
    logic [15:0] out_sound_o;

    modport master (
        output in_valid_i,
        output in_sound_i,
        input  out_valid_o,
        input  out_sound_o
    );

    modport slave (
        input  in_valid_i,
        input  in_sound_i,
        output out_valid_o,
        output out_sound_o
    );
endinterface
`default_nettype wire

// File: rtl/red_pitaya_guitar_out_level.sv
`default_nettype none
// ============================================================================
//  Module   : red_pitaya_guitar_out_level
//  Brief    : Output level stage. Scales each sample by a smoothly ramped
//             gain, handles mute with a soft ramp, saturates to 16 bits,
//             counts clipped samples and (optionally) tracks a decaying peak.
//  Options  : GUITAR_OUT_LEVEL_PEAK_EN - build the peak meter. When it is not
//             defined, peak_o is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module red_pitaya_guitar_out_level #(
    parameter int RAMP_STEP = 16,
    parameter int DECAY_DIV = 256
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    red_pitaya_guitar_out_level_if.slave        snd,
    input  logic [15:0]                         volume_i,
    input  logic                                mute_i,
    input  logic                                clip_clr_i,
    output logic                                muted_o,
    output logic [15:0]                         gain_o,
    output logic [15:0]                         clip_cnt_o,
    output logic [14:0]                         peak_o
);

    typedef enum logic [1:0] {
        ST_MUTED       = 2'd0,
        ST_UNMUTE_RAMP = 2'd1,
        ST_RUN         = 2'd2,
        ST_MUTE_RAMP   = 2'd3
    } state_t;

    localparam logic [16:0] c_STEP = 17'(RAMP_STEP);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_gain;
    logic [15:0]         w_gain_nxt;
    logic [15:0]         w_target;
    logic [16:0]         w_gain17;
    logic [16:0]         w_target17;
    logic                r_muted;

    logic signed [32:0]  w_in33;
    logic signed [32:0]  w_gain33;
    logic signed [32:0]  w_prod;
    logic signed [32:0]  r_prod;
    logic                r_v1;
    logic signed [17:0]  w_shift;
    logic                w_clip;
    logic [15:0]         w_sat;
    logic                w_clip_evt;
    logic                r_out_valid;
    logic [15:0]         r_out_sound;
    logic [15:0]         r_clip_cnt;
    logic                w_unused;

    // Target selection and one ramp step toward it; 17-bit math avoids wrap.
    always_comb begin
        w_target   = ((r_state == ST_RUN) || (r_state == ST_UNMUTE_RAMP)) ? volume_i : 16'h0000;
        w_gain17   = {1'b0, r_gain};
        w_target17 = {1'b0, w_target};
        w_gain_nxt = r_gain;
        if (snd.in_valid_i) begin
            if (w_gain17 < w_target17) begin
                w_gain_nxt = ((w_gain17 + c_STEP) < w_target17) ? 16'(w_gain17 + c_STEP) : w_target;
            end else if (w_gain17 > w_target17) begin
                w_gain_nxt = (w_gain17 > (w_target17 + c_STEP)) ? 16'(w_gain17 - c_STEP) : w_target;
            end
        end
    end

    // Next-state logic; mute requests take priority over ramp completion.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_MUTED: begin
                if (!mute_i) w_state_nxt = ST_UNMUTE_RAMP;
            end
            ST_UNMUTE_RAMP: begin
                if (mute_i)                       w_state_nxt = ST_MUTE_RAMP;
                else if (w_gain_nxt == volume_i)  w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (mute_i) w_state_nxt = ST_MUTE_RAMP;
            end
            ST_MUTE_RAMP: begin
                if (!mute_i)                      w_state_nxt = ST_UNMUTE_RAMP;
                else if (w_gain_nxt == 16'h0000)  w_state_nxt = ST_MUTED;
            end
            default: w_state_nxt = ST_MUTED;
        endcase
    end

    // State, gain and mute flag registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state <= ST_MUTED;
            r_gain  <= 16'h0000;
            r_muted <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
            r_muted <= (w_state_nxt == ST_MUTED);
        end
    end

    // Gain is zero-extended so the multiply stays signed with gain up to ~2.0.
    assign w_in33   = {{17{snd.in_sound_i[15]}}, snd.in_sound_i};
    assign w_gain33 = {17'b0, r_gain};
    assign w_prod   = w_in33 * w_gain33;

    // Stage 1: register the full product.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_v1   <= 1'b0;
            r_prod <= '0;
        end else begin
            r_v1 <= snd.in_valid_i;
            if (snd.in_valid_i) r_prod <= w_prod;
        end
    end

    // Q15 rescale; out of range whenever the top three bits disagree.
    assign w_shift    = r_prod[32:15];
    assign w_clip     = (w_shift[17:15] != 3'b000) && (w_shift[17:15] != 3'b111);
    assign w_sat      = w_clip ? (w_shift[17] ? 16'h8000 : 16'h7FFF) : w_shift[15:0];
    assign w_clip_evt = r_v1 && w_clip;

    // Stage 2: saturated output sample.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_out_valid <= 1'b0;
            r_out_sound <= 16'h0000;
        end else begin
            r_out_valid <= r_v1;
            if (r_v1) r_out_sound <= w_sat;
        end
    end

    // Saturating clip counter; a clear pulse beats a coincident clip.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_clip_cnt <= 16'h0000;
        end else if (clip_clr_i) begin
            r_clip_cnt <= 16'h0000;
        end else if (w_clip_evt && (r_clip_cnt != 16'hFFFF)) begin
            r_clip_cnt <= r_clip_cnt + 16'h0001;
        end
    end

`ifdef GUITAR_OUT_LEVEL_PEAK_EN
    localparam int c_DCNT_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [c_DCNT_W-1:0] c_DCNT_LAST = c_DCNT_W'(DECAY_DIV - 1);

    logic [15:0]         w_neg;
    logic [14:0]         w_abs;
    logic [14:0]         r_peak;
    logic [c_DCNT_W-1:0] r_dcnt;

    // Magnitude of the sample being emitted; full-scale negative maps to 32767.
    assign w_neg = 16'h0000 - w_sat;
    assign w_abs = (w_sat == 16'h8000) ? 15'h7FFF : (w_sat[15] ? w_neg[14:0] : w_sat[14:0]);

    // Peak hold with a linear decay paced by the decay counter.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_peak <= 15'h0000;
            r_dcnt <= '0;
        end else if (r_v1) begin
            if (w_abs > r_peak) begin
                r_peak <= w_abs;
                r_dcnt <= '0;
            end else if (r_dcnt == c_DCNT_LAST) begin
                if (r_peak != 15'h0000) r_peak <= r_peak - 15'h0001;
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
        end
    end

    assign peak_o   = r_peak;
    assign w_unused = ^r_prod[14:0];
`else
    assign peak_o   = 15'h0000;
    assign w_unused = (^r_prod[14:0]) ^ (DECAY_DIV != 0);
`endif

    assign snd.out_valid_o = r_out_valid;
    assign snd.out_sound_o = r_out_sound;
    assign muted_o         = r_muted;
    assign gain_o          = r_gain;
    assign clip_cnt_o      = r_clip_cnt;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_guitar_out_level.sv
`default_nettype none
// ============================================================================
//  Module   : tb_red_pitaya_guitar_out_level
//  Brief    : Scoreboard bench for the guitar output level stage. Stimulus
//             pushes the expected output of every strobe; a monitor pops and
//             compares whenever the DUT presents an output sample.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_red_pitaya_guitar_out_level;

    localparam int c_RAMP_STEP = 16;
    localparam int c_DECAY_DIV = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] volume = 16'h8000;
    logic        mute = 1'b0;
    logic        clip_clr = 1'b0;
    logic        muted;
    logic [15:0] gain;
    logic [15:0] clip_cnt;
    logic [14:0] peak;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    red_pitaya_guitar_out_level_if sif ();

    red_pitaya_guitar_out_level #(
        .RAMP_STEP (c_RAMP_STEP),
        .DECAY_DIV (c_DECAY_DIV)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .snd        (sif),
        .volume_i   (volume),
        .mute_i     (mute),
        .clip_clr_i (clip_clr),
        .muted_o    (muted),
        .gain_o     (gain),
        .clip_cnt_o (clip_cnt),
        .peak_o     (peak)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] s, input logic [15:0] e);
        sif.in_valid_i = 1'b1;
        sif.in_sound_i = s;
        exp_q.push_back(e);
        tick();
        sif.in_valid_i = 1'b0;
    endtask

    // Reference scaling: Q15 multiply with floor shift and 16-bit saturation.
    function automatic logic [15:0] scale(input logic [15:0] s, input int g);
        longint p;
        p = longint'($signed(s)) * longint'(g);
        p = p >>> 15;
        if (p > 32767)  return 16'h7FFF;
        if (p < -32768) return 16'h8000;
        return p[15:0];
    endfunction

    function automatic int exp_peak(input int j);
`ifdef GUITAR_OUT_LEVEL_PEAK_EN
        return 32767 - (j / c_DECAY_DIV);
`else
        return 0 * j;
`endif
    endfunction

    task automatic wait_unmuted(input string name);
        int n;
        n = 0;
        while (muted && (n < 20)) begin
            tick();
            n++;
        end
        check(name, 32'(muted), 32'd0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (sif.out_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_sound", 32'(sif.out_sound_o), 32'(mon_exp));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int n_ov;
        sif.in_valid_i = 1'b0;
        sif.in_sound_i = 16'h0000;
        repeat (3) tick();

        // Reset state
        check("rst_out_valid", 32'(sif.out_valid_o), 32'd0);
        check("rst_out_sound", 32'(sif.out_sound_o), 32'd0);
        check("rst_gain", 32'(gain), 32'd0);
        check("rst_muted", 32'(muted), 32'd1);
        check("rst_clip_cnt", 32'(clip_cnt), 32'd0);
        check("rst_peak", 32'(peak), 32'd0);

        // Unity ramp from soft start
        rstn = 1'b1;
        tick();
        wait_unmuted("softstart_unmuted");
        for (int k = 0; k < 2048; k++) begin
            strobe(16'd1000, scale(16'd1000, c_RAMP_STEP * k));
            if (k == 0) check("ramp_gain_16", 32'(gain), 32'd16);
            if (k == 1) check("ramp_gain_32", 32'(gain), 32'd32);
        end
        check("unity_gain", 32'(gain), 32'h8000);
        for (int k = 0; k < 6; k++) strobe(16'd1000, 16'd1000);
        check("unity_gain_hold", 32'(gain), 32'h8000);
        repeat (3) tick();

        // Saturation and clip counting at ~2.0 gain
        volume = 16'hFFFF;
        for (int k = 0; k < 2048; k++) strobe(16'd0, 16'd0);
        check("gain_max", 32'(gain), 32'hFFFF);
        check("clip_before", 32'(clip_cnt), 32'd0);
        strobe(16'h4E20, 16'h7FFF);
        strobe(16'hB1E0, 16'h8000);
        repeat (2) tick();
        check("clip_two", 32'(clip_cnt), 32'd2);
        sif.in_valid_i = 1'b1;
        sif.in_sound_i = 16'h4E20;
        exp_q.push_back(16'h7FFF);
        tick();
        sif.in_valid_i = 1'b0;
        clip_clr = 1'b1;
        tick();
        clip_clr = 1'b0;
        tick();
        check("clip_clr_wins", 32'(clip_cnt), 32'd0);
        strobe(16'h4E20, 16'h7FFF);
        repeat (2) tick();
        check("clip_one", 32'(clip_cnt), 32'd1);

        // Mute round trip
        volume = 16'h8000;
        for (int k = 0; k < 2048; k++) strobe(16'd0, 16'd0);
        check("back_to_unity", 32'(gain), 32'h8000);
        mute = 1'b1;
        tick();
        for (int k = 0; k < 2048; k++) begin
            g = 32'h8000 - c_RAMP_STEP * k;
            strobe(16'd1000, scale(16'd1000, g));
            if (k == 0) check("mute_first_step", 32'(gain), 32'h7FF0);
        end
        check("mute_gain_zero", 32'(gain), 32'd0);
        check("mute_muted", 32'(muted), 32'd1);
        for (int k = 0; k < 3; k++) strobe(16'd1000, 16'd0);
        mute = 1'b0;
        tick();
        check("unmute_from_muted", 32'(muted), 32'd0);
        for (int k = 0; k < 2048; k++) strobe(16'd0, 16'd0);
        check("unmute_gain", 32'(gain), 32'h8000);
        mute = 1'b1;
        tick();
        for (int k = 0; k < 1024; k++) begin
            g = 32'h8000 - c_RAMP_STEP * k;
            strobe(16'd1000, scale(16'd1000, g));
        end
        check("mid_mute_gain", 32'(gain), 32'h4000);
        mute = 1'b0;
        tick();
        for (int k = 0; k < 1024; k++) begin
            g = 32'h4000 + c_RAMP_STEP * k;
            strobe(16'd1000, scale(16'd1000, g));
            if (k == 0) check("reversal_up", 32'(gain), 32'h4010);
        end
        check("reversal_gain", 32'(gain), 32'h8000);
        check("reversal_not_muted", 32'(muted), 32'd0);
        repeat (3) tick();

        // Reset with two samples in flight
        sif.in_valid_i = 1'b1;
        sif.in_sound_i = 16'd1000;
        tick();
        sif.in_sound_i = 16'd2000;
        rstn = 1'b0;
        tick();
        sif.in_valid_i = 1'b0;
        rstn = 1'b1;
        check("rst_mid_out_valid", 32'(sif.out_valid_o), 32'd0);
        check("rst_mid_gain", 32'(gain), 32'd0);
        check("rst_mid_muted", 32'(muted), 32'd1);
        check("rst_mid_clip_cnt", 32'(clip_cnt), 32'd0);
        n_ov = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (sif.out_valid_o) n_ov++;
        end
        check("rst_no_out_valid", 32'(n_ov), 32'd0);

        // Peak meter
        volume = 16'hFFFF;
        wait_unmuted("peak_unmuted");
        for (int k = 0; k < 4096; k++) strobe(16'd0, 16'd0);
        check("peak_gain_max", 32'(gain), 32'hFFFF);
        repeat (2) tick();
        check("peak_idle", 32'(peak), 32'd0);
        strobe(16'hB1E0, 16'h8000);
        tick();
        check("peak_full", 32'(peak), 32'(exp_peak(0)));
        for (int j = 1; j <= 9; j++) begin
            strobe(16'd0, 16'd0);
            tick();
            check("peak_decay", 32'(peak), 32'(exp_peak(j)));
        end

        repeat (4) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/red_pitaya_guitar_out_level.md
# red_pitaya_guitar_out_level

Output level stage for the guitar effects chain. It sits after the drive/saturation amplifier and before the DAC path. It scales each saturated 16-bit sample by a user volume whose gain ramps smoothly, so volume changes and mute cause no zipper noise or clicks. It also reports output clipping and a decaying peak level to the register bank.

## Interface
- `RAMP_STEP`, default 16: gain increment/decrement applied per accepted sample while ramping.
- `DECAY_DIV`, default 256: number of accepted samples without a new peak before `peak_o` decays by 1.
- `clk_i` in 1: system clock; all logic on rising edge.
- `rstn_i` in 1: reset, synchronous and active-low.
- `in_valid_i` in 1: one-cycle strobe; `in_sound_i` is valid this cycle.
- `in_sound_i` in 16: signed two's-complement sample from the amplifier.
- `volume_i` in 16: unsigned target gain; 0x8000 = unity, 0xFFFF ≈ 2.0, 0 = silence.
- `mute_i` in 1: level-sensitive mute request.
- `clip_clr_i` in 1: one-cycle pulse that clears `clip_cnt_o`.
- `out_valid_o` out 1: one-cycle strobe marking a valid `out_sound_o`.
- `out_sound_o` out 16: signed scaled and saturated sample.
- `muted_o` out 1: high while in state MUTED.
- `gain_o` out 16: current ramped gain register.
- `clip_cnt_o` out 16: saturating count of clipped output samples.
- `peak_o` out 15: decaying peak of |out_sound_o|.

## Operation
- **Gain register.** `gain` is unsigned 16-bit. On each `in_valid_i`, the sample is multiplied by the current `gain`. Then `gain` steps toward `target`:
  - if `gain < target`: `gain = min(gain+RAMP_STEP, target)`;
  - if `gain > target`: `gain = max(gain-RAMP_STEP, target)`.
  - Compute with 17-bit intermediates, so there is no wrap past 0 or 0xFFFF.
- **Target selection.** `target` = `volume_i` in RUN and UNMUTE_RAMP; `target` = 0 in MUTE_RAMP and MUTED.
- **Arithmetic.**
  - Product = signed(`in_sound_i`) × signed({1'b0, `gain`}), 33-bit.
  - Arithmetic shift right by 15 gives an 18-bit value.
  - Saturate to 16 bits: values > 32767 → 0x7FFF, values < −32768 → 0x8000.
  - Each saturated sample is a clip event.
- **State machine.**
  - MUTED: `gain` = 0 and output samples are 0. Go to UNMUTE_RAMP when `mute_i` = 0.
  - UNMUTE_RAMP: go to RUN when `gain == volume_i` after the update. Go to MUTE_RAMP if `mute_i` = 1; the mute check takes priority.
  - RUN: go to MUTE_RAMP when `mute_i` = 1. A change of `volume_i` ramps without leaving RUN.
  - MUTE_RAMP: go to MUTED when `gain` reaches 0. Go to UNMUTE_RAMP if `mute_i` = 0.
  - State transitions are evaluated every clock. Gain steps happen only on `in_valid_i`.
- **Clip counter.** Increments on each clip event and saturates at 0xFFFF. If `clip_clr_i` and a clip event occur in the same cycle, the clear wins and the event is dropped.
- **Peak meter.**
  - On `out_valid_o`, compute a = |`out_sound_o`|; 0x8000 maps to 32767.
  - If a > `peak_o`: `peak_o` = a and the decay counter clears.
  - Otherwise the decay counter increments. When it reaches `DECAY_DIV`−1, `peak_o` decrements (floor 0) and the counter clears.

## Timing
- Two-stage pipeline; `out_valid_o` and `out_sound_o` follow `in_valid_i` by exactly 2 cycles.
  - Stage 1 registers the product.
  - Stage 2 shifts and saturates.
- Throughput is 1 sample per cycle; back-to-back strobes are allowed.
- `clip_cnt_o` and `peak_o` update in the same cycle `out_valid_o` is high.
- `gain_o` and `muted_o` are registered and reflect state 1 cycle after the causing edge.
- Reset values:
  - state MUTED, `gain` 0, `muted_o` 1;
  - `out_valid_o` 0, `out_sound_o` 0;
  - `clip_cnt_o` 0, `peak_o` 0, decay counter 0;
  - pipeline cleared.
- Reset asserted mid-ramp or mid-pipeline discards in-flight samples. No `out_valid_o` fires for them.
- After reset release with `mute_i` = 0, the block soft-starts via UNMUTE_RAMP.

## Configuration
- `GUITAR_OUT_LEVEL_PEAK_EN` defined: peak meter and decay counter are built as described.
- `GUITAR_OUT_LEVEL_PEAK_EN` undefined: both are omitted and `peak_o` is tied to 0. All other behaviour is unchanged.

## Test plan
- **Unity ramp and latency.** Reset, `mute_i`=0, `volume_i`=0x8000, strobes every cycle with `in_sound_i`=1000.
  - `gain_o` rises 0, 16, 32, … and reaches 0x8000 after 2048 samples; state RUN.
  - Then `out_sound_o`=1000, exactly 2 cycles after each strobe.
- **Saturation and clip counting.** `volume_i`=0xFFFF settled, `in_sound_i`=+20000 then −20000.
  - Outputs are 0x7FFF then 0x8000; `clip_cnt_o` increments by 2.
  - A `clip_clr_i` pulse in the same cycle as a third clip leaves the count at 0.
- **Mute round trip.** In RUN at 0x8000, assert `mute_i`.
  - `gain_o` reaches 0 after 2048 strobes, then `muted_o`=1 and outputs are 0.
  - Deassert `mute_i` at gain 0x4000 during the ramp: state goes to UNMUTE_RAMP and gain climbs back to 0x8000 without reaching 0.
- **Peak decay** (macro defined, `DECAY_DIV`=4). Output one sample at 0x8000, then samples of 0.
  - `peak_o`=32767, then it decrements by 1 every 4 samples.
  - With the macro undefined, `peak_o` stays 0.
- **Reset mid-operation.** Assert `rstn_i`=0 for one cycle with two samples in the pipeline.
  - No `out_valid_o` follows; `gain_o`=0, `muted_o`=1, `clip_cnt_o`=0.
